// File: rtl/tl_ul_initiator_if.sv
// TileLink-UL A/D channel bundle between an initiator (master) and a target (slave).
// Signal names follow the tlm_* port naming of the tl_ul_initiator block.
interface tl_ul_initiator_if #(
    parameter int TL_RS  = 4,
    parameter int ADDR_W = 22
);
    // A channel: request from initiator to target
    logic [2:0]        tlm_a_opcode;
    logic [2:0]        tlm_a_param;
    logic [3:0]        tlm_a_size;
    logic [TL_RS-1:0]  tlm_a_source;
    logic [ADDR_W-1:0] tlm_a_address;
    logic [3:0]        tlm_a_mask;
    logic [31:0]       tlm_a_data;
    logic              tlm_a_corrupt;
    logic              tlm_a_valid;
    logic              tlm_a_ready;

    // D channel: response from target to initiator
    logic [2:0]        tlm_d_opcode;
    logic [1:0]        tlm_d_param;
    logic [3:0]        tlm_d_size;
    logic [TL_RS-1:0]  tlm_d_source;
    logic              tlm_d_denied;
    logic [31:0]       tlm_d_data;
    logic              tlm_d_corrupt;
    logic              tlm_d_valid;
    logic              tlm_d_ready;

    modport master (
        output tlm_a_opcode, tlm_a_param, tlm_a_size, tlm_a_source,
               tlm_a_address, tlm_a_mask, tlm_a_data, tlm_a_corrupt, tlm_a_valid,
        input  tlm_a_ready,
        input  tlm_d_opcode, tlm_d_param, tlm_d_size, tlm_d_source,
               tlm_d_denied, tlm_d_data, tlm_d_corrupt, tlm_d_valid,
        output tlm_d_ready
    );

    modport slave (
        input  tlm_a_opcode, tlm_a_param, tlm_a_size, tlm_a_source,
               tlm_a_address, tlm_a_mask, tlm_a_data, tlm_a_corrupt, tlm_a_valid,
        output tlm_a_ready,
        output tlm_d_opcode, tlm_d_param, tlm_d_size, tlm_d_source,
               tlm_d_denied, tlm_d_data, tlm_d_corrupt, tlm_d_valid,
        input  tlm_d_ready
    );
endinterface

// File: rtl/tl_ul_initiator.sv
// TL-UL initiator: one single-word command in flight, turned into Get/PutFull/PutPartial.
// Optional D-wait timeout with stale-beat draining is enabled by defining TL_INIT_TIMEOUT_EN.
module tl_ul_initiator #(
    parameter int               TL_RS          = 4,
    parameter int               ADDR_W         = 22,
    parameter logic [TL_RS-1:0] SOURCE_ID      = '0,
    parameter int               TIMEOUT_CYCLES = 1024
) (
    input  logic              tlm_clock_i,
    input  logic              tlm_resetn_i,

    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_address_i,
    input  logic [31:0]       cmd_data_i,
    input  logic [3:0]        cmd_mask_i,

    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_data_o,
    output logic              rsp_error_o,

    tl_ul_initiator_if.master tl
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AREQ,
        ST_DWAIT,
        ST_RSP
    } state_e;

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_ACK         = 3'd0;
    localparam logic [2:0] OP_ACK_DATA    = 3'd1;

    state_e            state_q, state_d;
    logic              a_valid_q, a_valid_d;
    logic [2:0]        a_opcode_q, a_opcode_d;
    logic [3:0]        a_size_q, a_size_d;
    logic [TL_RS-1:0]  a_source_q, a_source_d;
    logic [ADDR_W-1:0] a_address_q, a_address_d;
    logic [3:0]        a_mask_q, a_mask_d;
    logic [31:0]       a_data_q, a_data_d;
    logic              is_get_q, is_get_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic              rsp_error_q, rsp_error_d;
    logic              d_ready;
    logic              d_bad;

`ifdef TL_INIT_TIMEOUT_EN
    logic              stale_q, stale_d;
    logic [31:0]       tmo_cnt_q, tmo_cnt_d;
`endif

    // Fields the initiator never needs; folded here so they are visibly consumed.
    logic unused_inputs;
    assign unused_inputs = ^{tl.tlm_d_param, tl.tlm_d_size, cmd_address_i[1:0]};

`ifdef TL_INIT_TIMEOUT_EN
    assign cmd_ready_o = (state_q == ST_IDLE) && !stale_q;
    assign d_ready     = (state_q == ST_DWAIT) || ((state_q == ST_IDLE) && stale_q);
`else
    assign cmd_ready_o = (state_q == ST_IDLE);
    assign d_ready     = (state_q == ST_DWAIT);
`endif

    assign d_bad = tl.tlm_d_denied || tl.tlm_d_corrupt ||
                   (tl.tlm_d_source != SOURCE_ID) ||
                   (tl.tlm_d_opcode != (is_get_q ? OP_ACK_DATA : OP_ACK));

    // NOTE: every *_d gets its hold value first, so no path through the case can infer a latch.
    always_comb begin
        state_d     = state_q;
        a_valid_d   = a_valid_q;
        a_opcode_d  = a_opcode_q;
        a_size_d    = a_size_q;
        a_source_d  = a_source_q;
        a_address_d = a_address_q;
        a_mask_d    = a_mask_q;
        a_data_d    = a_data_q;
        is_get_d    = is_get_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;
`ifdef TL_INIT_TIMEOUT_EN
        stale_d     = stale_q;
        tmo_cnt_d   = tmo_cnt_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
`ifdef TL_INIT_TIMEOUT_EN
                // The beat belonging to a timed-out request is swallowed here.
                if (stale_q && tl.tlm_d_valid) begin
                    stale_d = 1'b0;
                end
`endif
                if (cmd_valid_i && cmd_ready_o) begin
                    is_get_d    = !cmd_write_i;
                    a_valid_d   = 1'b1;
                    a_size_d    = 4'd2;
                    a_source_d  = SOURCE_ID;
                    a_address_d = {cmd_address_i[ADDR_W-1:2], 2'b00};
                    if (cmd_write_i) begin
                        a_opcode_d = (cmd_mask_i == 4'hF) ? OP_PUT_FULL : OP_PUT_PARTIAL;
                        a_mask_d   = cmd_mask_i;
                        a_data_d   = cmd_data_i;
                    end else begin
                        a_opcode_d = OP_GET;
                        a_mask_d   = 4'hF;
                        a_data_d   = 32'h0;
                    end
                    state_d = ST_AREQ;
                end
            end

            ST_AREQ: begin
                if (tl.tlm_a_ready) begin
                    a_valid_d = 1'b0;
                    state_d   = ST_DWAIT;
`ifdef TL_INIT_TIMEOUT_EN
                    tmo_cnt_d = 32'd0;
`endif
                end
            end

            ST_DWAIT: begin
                if (tl.tlm_d_valid) begin
                    rsp_valid_d = 1'b1;
                    rsp_error_d = d_bad;
                    rsp_data_d  = is_get_q ? tl.tlm_d_data : 32'h0;
                    state_d     = ST_RSP;
                end
`ifdef TL_INIT_TIMEOUT_EN
                // A beat in the same cycle as the limit wins over the timeout.
                else if (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                    rsp_data_d  = 32'hDEADBEEF;
                    stale_d     = 1'b1;
                    state_d     = ST_RSP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 32'd1;
                end
`endif
            end

            ST_RSP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge tlm_clock_i or negedge tlm_resetn_i) begin
        if (!tlm_resetn_i) begin
            state_q     <= ST_IDLE;
            a_valid_q   <= 1'b0;
            a_opcode_q  <= 3'd0;
            a_size_q    <= 4'd0;
            a_source_q  <= '0;
            a_address_q <= '0;
            a_mask_q    <= 4'd0;
            a_data_q    <= 32'h0;
            is_get_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_valid_q   <= a_valid_d;
            a_opcode_q  <= a_opcode_d;
            a_size_q    <= a_size_d;
            a_source_q  <= a_source_d;
            a_address_q <= a_address_d;
            a_mask_q    <= a_mask_d;
            a_data_q    <= a_data_d;
            is_get_q    <= is_get_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
        end
    end

`ifdef TL_INIT_TIMEOUT_EN
    always_ff @(posedge tlm_clock_i or negedge tlm_resetn_i) begin
        if (!tlm_resetn_i) begin
            stale_q   <= 1'b0;
            tmo_cnt_q <= 32'd0;
        end else begin
            stale_q   <= stale_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`endif

    assign tl.tlm_a_valid   = a_valid_q;
    assign tl.tlm_a_opcode  = a_opcode_q;
    assign tl.tlm_a_param   = 3'd0;
    assign tl.tlm_a_size    = a_size_q;
    assign tl.tlm_a_source  = a_source_q;
    assign tl.tlm_a_address = a_address_q;
    assign tl.tlm_a_mask    = a_mask_q;
    assign tl.tlm_a_data    = a_data_q;
    assign tl.tlm_a_corrupt = 1'b0;
    assign tl.tlm_d_ready   = d_ready;

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_error_o = rsp_error_q;

endmodule

// File: tb/tb_tl_ul_initiator.sv
// Scoreboard bench for tl_ul_initiator: directed vectors push expected A beats and
// responses; two monitors pop and compare on every A and rsp handshake.
module tb_tl_ul_initiator;

    localparam int ADDR_W = 22;
    localparam int TL_RS  = 4;
`ifdef TL_INIT_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 1024;
`endif

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_address;
    logic [31:0]       cmd_data;
    logic [3:0]        cmd_mask;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_data;
    logic              rsp_error;

    tl_ul_initiator_if #(.TL_RS(TL_RS), .ADDR_W(ADDR_W)) tl ();

    tl_ul_initiator #(
        .TL_RS(TL_RS), .ADDR_W(ADDR_W), .SOURCE_ID(4'd0), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .tlm_clock_i  (clk),
        .tlm_resetn_i (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_write_i  (cmd_write),
        .cmd_address_i(cmd_address),
        .cmd_data_i   (cmd_data),
        .cmd_mask_i   (cmd_mask),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_data_o   (rsp_data),
        .rsp_error_o  (rsp_error),
        .tl           (tl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [3:0]        mask;
        int                a_dly;
        int                d_dly;
        logic [2:0]        d_op;
        logic [3:0]        d_src;
        logic              d_den;
        logic              d_cor;
        logic [31:0]       d_data;
        int                r_dly;
        logic [2:0]        e_op;
        logic [3:0]        e_mask;
        logic [31:0]       e_rdata;
        logic              e_err;
    } vec_t;

    typedef struct {
        logic [2:0]        op;
        logic [3:0]        mask;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } a_exp_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } r_exp_t;

    a_exp_t exp_a[$];
    r_exp_t exp_r[$];
    vec_t   vecs[10];
    int     checks   = 0;
    int     failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // A-channel monitor: compares every accepted request beat against the scoreboard.
    initial begin
        a_exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && tl.tlm_a_valid && tl.tlm_a_ready) begin
                check("a_queue_nonempty", 32'(exp_a.size() != 0), 32'd1);
                if (exp_a.size() != 0) begin
                    e = exp_a.pop_front();
                    check("a_opcode",  32'(tl.tlm_a_opcode),  32'(e.op));
                    check("a_mask",    32'(tl.tlm_a_mask),    32'(e.mask));
                    check("a_address", 32'(tl.tlm_a_address), 32'(e.addr));
                    check("a_data",    tl.tlm_a_data,         e.data);
                    check("a_size",    32'(tl.tlm_a_size),    32'd2);
                    check("a_param",   32'(tl.tlm_a_param),   32'd0);
                    check("a_source",  32'(tl.tlm_a_source),  32'd0);
                    check("a_corrupt", 32'(tl.tlm_a_corrupt), 32'd0);
                end
            end
        end
    end

    // Response monitor: compares every consumed response against the scoreboard.
    initial begin
        r_exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && rsp_valid && rsp_ready) begin
                check("rsp_queue_nonempty", 32'(exp_r.size() != 0), 32'd1);
                if (exp_r.size() != 0) begin
                    e = exp_r.pop_front();
                    check("rsp_data",  rsp_data,         e.data);
                    check("rsp_error", 32'(rsp_error),   32'(e.err));
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic issue_cmd(input logic wr, input logic [ADDR_W-1:0] addr,
                             input logic [31:0] data, input logic [3:0] mask);
        int n = 0;
        cmd_write   = wr;
        cmd_address = addr;
        cmd_data    = data;
        cmd_mask    = mask;
        cmd_valid   = 1'b1;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic pulse_a_ready();
        tl.tlm_a_ready = 1'b1;
        @(negedge clk);
        tl.tlm_a_ready = 1'b0;
    endtask

    task automatic send_d(input logic [2:0] op, input logic [3:0] src, input logic den,
                          input logic cor, input logic [31:0] data);
        tl.tlm_d_opcode  = op;
        tl.tlm_d_source  = src;
        tl.tlm_d_denied  = den;
        tl.tlm_d_corrupt = cor;
        tl.tlm_d_data    = data;
        tl.tlm_d_valid   = 1'b1;
        @(negedge clk);
        tl.tlm_d_valid   = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [ADDR_W-1:0] e_addr = {v.addr[ADDR_W-1:2], 2'b00};
        logic [31:0]       e_data = v.wr ? v.data : 32'h0;
        exp_a.push_back('{v.e_op, v.e_mask, e_addr, e_data});
        exp_r.push_back('{v.e_rdata, v.e_err});
        issue_cmd(v.wr, v.addr, v.data, v.mask);
        check("a_valid_after_accept", 32'(tl.tlm_a_valid), 32'd1);
        check("d_ready_in_areq",      32'(tl.tlm_d_ready), 32'd0);
        for (int k = 0; k < v.a_dly; k++) begin
            check("stall_a_valid",   32'(tl.tlm_a_valid),   32'd1);
            check("stall_a_opcode",  32'(tl.tlm_a_opcode),  32'(v.e_op));
            check("stall_a_address", 32'(tl.tlm_a_address), 32'(e_addr));
            check("stall_a_mask",    32'(tl.tlm_a_mask),    32'(v.e_mask));
            check("stall_a_data",    tl.tlm_a_data,         e_data);
            check("stall_cmd_ready", 32'(cmd_ready),        32'd0);
            @(negedge clk);
        end
        pulse_a_ready();
        check("a_valid_cleared", 32'(tl.tlm_a_valid), 32'd0);
        for (int k = 0; k < v.d_dly; k++) begin
            check("dwait_d_ready", 32'(tl.tlm_d_ready), 32'd1);
            @(negedge clk);
        end
        check("d_ready_in_dwait", 32'(tl.tlm_d_ready), 32'd1);
        send_d(v.d_op, v.d_src, v.d_den, v.d_cor, v.d_data);
        check("rsp_valid_latency", 32'(rsp_valid), 32'd1);
        for (int k = 0; k < v.r_dly; k++) begin
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_rsp_data",  rsp_data,       v.e_rdata);
            check("hold_rsp_error", 32'(rsp_error), 32'(v.e_err));
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid_cleared", 32'(rsp_valid), 32'd0);
        check("cmd_ready_after",   32'(cmd_ready), 32'd1);
    endtask

    initial begin
        //            wr  addr       data          mask  aD dD dop src den cor d_data        rD eop emask e_rdata     err
        vecs[0] = '{1'b0, 22'h000004, 32'hCAFE0000, 4'h0, 0, 3, 3'd1, 4'd0, 1'b0, 1'b0, 32'h00000001, 0, 3'd4, 4'hF, 32'h00000001, 1'b0};
        vecs[1] = '{1'b1, 22'h002080, 32'hFFFFFFFE, 4'hF, 0, 0, 3'd0, 4'd0, 1'b0, 1'b0, 32'h12345678, 0, 3'd0, 4'hF, 32'h00000000, 1'b0};
        vecs[2] = '{1'b1, 22'h002080, 32'hFFFFFFFE, 4'h3, 0, 0, 3'd0, 4'd0, 1'b0, 1'b0, 32'h00000000, 0, 3'd1, 4'h3, 32'h00000000, 1'b0};
        vecs[3] = '{1'b0, 22'h000010, 32'h00000000, 4'h0, 5, 0, 3'd1, 4'd0, 1'b0, 1'b0, 32'h55AA00FF, 0, 3'd4, 4'hF, 32'h55AA00FF, 1'b0};
        vecs[4] = '{1'b0, 22'h000020, 32'h00000000, 4'h0, 0, 1, 3'd1, 4'd0, 1'b1, 1'b0, 32'hA5A5A5A5, 0, 3'd4, 4'hF, 32'hA5A5A5A5, 1'b1};
        vecs[5] = '{1'b0, 22'h000024, 32'h00000000, 4'h0, 0, 0, 3'd1, 4'd0, 1'b0, 1'b1, 32'h11111111, 0, 3'd4, 4'hF, 32'h11111111, 1'b1};
        vecs[6] = '{1'b1, 22'h000030, 32'h0BADF00D, 4'hC, 0, 0, 3'd0, 4'd3, 1'b0, 1'b0, 32'h00000000, 0, 3'd1, 4'hC, 32'h00000000, 1'b1};
        vecs[7] = '{1'b0, 22'h000034, 32'h00000000, 4'h0, 0, 0, 3'd0, 4'd0, 1'b0, 1'b0, 32'h22222222, 0, 3'd4, 4'hF, 32'h22222222, 1'b1};
        vecs[8] = '{1'b1, 22'h00ABC7, 32'h13572468, 4'hF, 1, 2, 3'd0, 4'd0, 1'b0, 1'b0, 32'h99999999, 4, 3'd0, 4'hF, 32'h00000000, 1'b0};
        vecs[9] = '{1'b0, 22'h3FFFFF, 32'h00000000, 4'h0, 0, 0, 3'd1, 4'd0, 1'b0, 1'b0, 32'h87654321, 2, 3'd4, 4'hF, 32'h87654321, 1'b0};

        rst_n            = 1'b0;
        cmd_valid        = 1'b0;
        cmd_write        = 1'b0;
        cmd_address      = '0;
        cmd_data         = 32'h0;
        cmd_mask         = 4'h0;
        rsp_ready        = 1'b0;
        tl.tlm_a_ready   = 1'b0;
        tl.tlm_d_valid   = 1'b0;
        tl.tlm_d_opcode  = 3'd0;
        tl.tlm_d_param   = 2'd0;
        tl.tlm_d_size    = 4'd2;
        tl.tlm_d_source  = '0;
        tl.tlm_d_denied  = 1'b0;
        tl.tlm_d_data    = 32'h0;
        tl.tlm_d_corrupt = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_a_valid",   32'(tl.tlm_a_valid), 32'd0);
        check("reset_d_ready",   32'(tl.tlm_d_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid),      32'd0);
        check("reset_rsp_data",  rsp_data,            32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Reset in the middle of DWAIT drops the request with no response.
        exp_a.push_back('{3'd4, 4'hF, 22'h000040, 32'h0});
        issue_cmd(1'b0, 22'h000040, 32'h0, 4'h0);
        pulse_a_ready();
        check("pre_reset_d_ready", 32'(tl.tlm_d_ready), 32'd1);
        check("pre_reset_rsp_data", rsp_data, 32'h87654321);
        #3 rst_n = 1'b0;
        #1;
        check("async_a_valid",   32'(tl.tlm_a_valid),   32'd0);
        check("async_d_ready",   32'(tl.tlm_d_ready),   32'd0);
        check("async_rsp_valid", 32'(rsp_valid),        32'd0);
        check("async_rsp_data",  rsp_data,              32'h0);
        check("async_rsp_error", 32'(rsp_error),        32'd0);
        check("async_a_address", 32'(tl.tlm_a_address), 32'd0);
        check("async_a_opcode",  32'(tl.tlm_a_opcode),  32'd0);
        check("async_a_mask",    32'(tl.tlm_a_mask),    32'd0);
        check("async_a_size",    32'(tl.tlm_a_size),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
        run_vec(vecs[0]);

`ifdef TL_INIT_TIMEOUT_EN
        begin
            int n = 0;
            exp_a.push_back('{3'd4, 4'hF, 22'h000008, 32'h0});
            exp_r.push_back('{32'hDEADBEEF, 1'b1});
            issue_cmd(1'b0, 22'h000008, 32'h0, 4'h0);
            pulse_a_ready();
            while (!rsp_valid && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("timeout_rsp_valid", 32'(rsp_valid), 32'd1);
            check("timeout_cycles",    32'(n),         32'd8);
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            check("stale_cmd_ready", 32'(cmd_ready),        32'd0);
            check("stale_d_ready",   32'(tl.tlm_d_ready),   32'd1);
            send_d(3'd1, 4'd0, 1'b0, 1'b0, 32'h77777777);
            check("drained_cmd_ready", 32'(cmd_ready),      32'd1);
            check("drained_d_ready",   32'(tl.tlm_d_ready), 32'd0);
            check("drained_rsp_valid", 32'(rsp_valid),      32'd0);
            run_vec(vecs[3]);
        end
`endif

        repeat (2) @(negedge clk);
        check("a_queue_drained",   32'(exp_a.size()), 32'd0);
        check("rsp_queue_drained", 32'(exp_r.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
